// File: rtl/sigma_delta_dac_ice40.sv
// rtl/sigma_delta_dac_ice40.sv - first-order sigma-delta DAC with linear interpolation
// One sample per 2^RATE_BITS-clock frame, ramped over 2^INTERP_BITS subticks into a 1-bit stream.
module sigma_delta_dac_ice40 #(
  parameter int DAC_WIDTH   = 8,
  parameter int RATE_BITS   = 10,
  parameter int INTERP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DAC_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 sample_req,
  output logic                 underrun,
  output logic                 analog_out
);

  localparam int AW    = DAC_WIDTH + INTERP_BITS;
  localparam int SUB_W = RATE_BITS - INTERP_BITS;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [RATE_BITS-1:0]        rate_cnt_q, rate_cnt_d;
  logic [DAC_WIDTH-1:0]        hold_q, hold_d;
  logic                        hold_full_q, hold_full_d;
  logic [DAC_WIDTH-1:0]        target_q, target_d;
  logic signed [DAC_WIDTH:0]   delta_q, delta_d;
  logic [AW-1:0]               cur_q, cur_d;
  logic [AW-1:0]               acc_q, acc_d;
  logic                        analog_q, analog_d;
  logic                        req_q, req_d;
  logic                        underrun_q, underrun_d;

  logic          frame_tick;
  logic          subtick;
  logic          accept;
  logic [AW-1:0] delta_ext;
  logic [AW:0]   mod_sum;

  assign frame_tick = &rate_cnt_q;

  if (SUB_W > 0) begin : g_sub
    assign subtick = &rate_cnt_q[SUB_W-1:0];
  end else begin : g_sub_all
    assign subtick = 1'b1;
  end

  assign accept    = sample_valid && !hold_full_q;
  assign delta_ext = AW'(delta_q);
  assign mod_sum   = {1'b0, acc_q} + {1'b0, cur_q};

  assign sample_ready = ~hold_full_q;
  assign sample_req   = req_q;
  assign underrun     = underrun_q;
  assign analog_out   = analog_q;

  always_comb begin
    state_d     = state_q;
    rate_cnt_d  = rate_cnt_q + 1'b1;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    target_d    = target_q;
    delta_d     = delta_q;
    cur_d       = cur_q;
    acc_d       = mod_sum[AW-1:0];
    analog_d    = mod_sum[AW];
    req_d       = frame_tick;
    underrun_d  = 1'b0;

    if (accept) begin
      hold_d      = sample_in;
      hold_full_d = 1'b1;
    end

    // The frame-tick add still uses the outgoing delta, which lands cur exactly on the old target.
    if (subtick) begin
      cur_d = cur_q + delta_ext;
    end

    if (frame_tick) begin
      if (hold_full_q) begin
        delta_d     = $signed({1'b0, hold_q}) - $signed({1'b0, target_q});
        target_d    = hold_q;
        hold_full_d = 1'b0;
        state_d     = RUN;
      end else begin
        delta_d    = '0;
        underrun_d = (state_q == RUN);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rate_cnt_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      target_q    <= '0;
      delta_q     <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      analog_q    <= 1'b0;
      req_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rate_cnt_q  <= rate_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      target_q    <= target_d;
      delta_q     <= delta_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      analog_q    <= analog_d;
      req_q       <= req_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule
